// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide controller.
//   - op encoding for the E-stage md op field
//   - default busy latencies for multiply-class and divide-class ops
//   - controller state encoding
//   - op-class helpers
// Optional feature macro: HILO_MADD_EN (enables MADD/MADDU/MSUB/MSUBU, ops 6-9).
package md_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Multiply-class ops: use MULT_CYCLES. Accumulate ops only exist when built in.
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef HILO_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_alu.sv
// md_alu: combinational 64-bit HI/LO result for the latched md operation.
// Ports:
//   op      in  4   latched operation
//   rs, rt  in  32  latched operands
//   hi, lo  in  32  current HI/LO (accumulate source, pass-through value)
//   res_hi  out 32  new HI
//   res_lo  out 32  new LO
// Optional feature macro: HILO_MADD_EN builds the accumulate/subtract path.
module md_alu
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide done on magnitudes; 0x80000000 has magnitude 0x80000000
    // unsigned, so the most-negative / -1 case falls out as 0x80000000 rem 0.
    assign a_neg  = (op == OP_DIV) && rs[31];
    assign b_neg  = (op == OP_DIV) && rt[31];
    assign a_mag  = a_neg ? (~rs + 32'd1) : rs;
    assign b_mag  = b_neg ? (~rt + 32'd1) : rt;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        {res_hi, res_lo} = {hi, lo};
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                // Zero divisor leaves HI/LO untouched.
                if (rt != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
`ifdef HILO_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: owns HI/LO; runs mult/div/madd with fixed busy latency and
// raises a D-stage stall for HI/LO-dependent instructions.
// Ports:
//   clk        in  1   clock
//   reset      in  1   synchronous active-high reset
//   start      in  1   E-stage issue strobe
//   op         in  4   md operation (see md_pkg)
//   rs_val     in  32  forwarded rs
//   rt_val     in  32  forwarded rt
//   md_use_d   in  1   D-stage instruction touches HI/LO
//   busy       out 1   countdown in progress
//   stall_req  out 1   hold F/D, bubble D->E
//   hi, lo     out 32  HI/LO registers
// Optional feature macro: HILO_MADD_EN (accept ops 6-9 as multiply-class).
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no op in flight; accepts start, MTHI/MTLO write
// ST_RUN  | counting down; commits ALU result when cnt == 1
module hilo_md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    md_alu u_alu (
        .op     (op_q),
        .rs     (rs_q),
        .rt     (rt_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul_op(op) || is_div_op(op)) begin
                            op_q    <= op;
                            rs_q    <= rs_val;
                            rt_q    <= rt_val;
                            cnt_q   <= is_div_op(op) ? CNT_W'(DIV_CYCLES)
                                                     : CNT_W'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo_q <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    // Issue-cycle term covers the D-stage op that arrives while busy is not yet up.
    assign stall_req = md_use_d & (busy_q | (start & (is_mul_op(op) | is_div_op(op))));

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed vector table, hand-written
// stall / MTHI-MTLO / reset-abort sequences, and randomized ops against a
// 64-bit arithmetic reference model. Honours HILO_MADD_EN when defined.
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_md_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

`ifdef HILO_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: architectural HI/LO, updated by plain 64-bit arithmetic.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic int ref_step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ps, pu, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        case (o)
            4'd0: begin {m_hi, m_lo} = ps; return 5; end
            4'd1: begin {m_hi, m_lo} = pu; return 5; end
            4'd2: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                return 10;
            end
            4'd3: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return 10;
            end
            4'd4: begin m_hi = a; return 0; end
            4'd5: begin m_lo = a; return 0; end
            4'd6, 4'd7, 4'd8, 4'd9: begin
                if (!MADD_ON) return 0;
                case (o)
                    4'd6:    {m_hi, m_lo} = acc + ps;
                    4'd7:    {m_hi, m_lo} = acc + pu;
                    4'd8:    {m_hi, m_lo} = acc - ps;
                    default: {m_hi, m_lo} = acc - pu;
                endcase
                return 5;
            end
            default: return 0;
        endcase
    endfunction

    // One-cycle issue, then count busy cycles (bounded).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n, e;
        logic [3:0]  o;
        logic [31:0] a, b;

        vecs[0] = '{4'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 5, 32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{4'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{4'd3, 32'd7, 32'd0, 32'h11, 32'h22, 10, 32'h11, 32'h22};
        vecs[4] = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 10, 32'h0, 32'h80000000};
        vecs[5] = '{4'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 10, 32'h1, 32'hFFFFFFFD};
        vecs[6] = MADD_ON ? '{4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 5, 32'h1, 32'h0}
                          : '{4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 32'hFFFFFFFF};
        vecs[7] = MADD_ON ? '{4'd8, 32'd2, 32'd3, 32'h0, 32'h0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA}
                          : '{4'd8, 32'd2, 32'd3, 32'h0, 32'h0, 0, 32'h0, 32'h0};
        vecs[8] = '{4'd12, 32'd9, 32'd9, 32'h5, 32'h6, 0, 32'h5, 32'h6};

        reset = 1'b1; start = 1'b0; op = 4'd0; rs_val = '0; rt_val = '0; md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        check("reset_hi",    64'(hi), 64'd0);
        check("reset_lo",    64'(lo), 64'd0);
        md_use_d = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            issue(4'd4, vecs[i].hi0, 32'd0, n);
            e = ref_step(4'd4, vecs[i].hi0, 32'd0);
            issue(4'd5, vecs[i].lo0, 32'd0, n);
            e = ref_step(4'd5, vecs[i].lo0, 32'd0);
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, n);
            e = ref_step(vecs[i].op, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cyc));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end

        // Stall across issue and busy; drops the cycle busy drops; back-to-back issue.
        @(negedge clk);
        start = 1'b1; op = 4'd0; rs_val = 32'd3; rt_val = 32'd4; md_use_d = 1'b1;
        #1 check("stall_issue", 64'(stall_req), 64'd1);
        e = ref_step(4'd0, 32'd3, 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("stall_busy%0d", k), 64'({busy, stall_req}), 64'd3);
        end
        @(negedge clk);
        #1;
        check("stall_drop", 64'({busy, stall_req}), 64'd0);
        check("stall_res", {32'(hi), 32'(lo)}, {m_hi, m_lo});
        start = 1'b1; op = 4'd1; rs_val = 32'd5; rt_val = 32'hFFFFFFFF; md_use_d = 1'b0;
        #1 check("no_use_no_stall", 64'(stall_req), 64'd0);
        e = ref_step(4'd1, 32'd5, 32'hFFFFFFFF);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_cycles", 64'(n), 64'd5);
        check("b2b_res", {32'(hi), 32'(lo)}, {m_hi, m_lo});

        // MTHI then MTLO back to back, with a HI/LO user in D: no stall, no busy.
        @(negedge clk);
        start = 1'b1; op = 4'd4; rs_val = 32'hDEADBEEF; md_use_d = 1'b1;
        #1 check("mthi_no_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        op = 4'd5; rs_val = 32'h12345678;
        #1 check("mthi_hi", 64'({busy, hi}), {31'd0, 1'b0, 32'hDEADBEEF});
        @(negedge clk);
        start = 1'b0; md_use_d = 1'b0;
        #1 check("mtlo_lo", 64'({busy, lo}), {31'd0, 1'b0, 32'h12345678});
        check("mtlo_hi", 64'(hi), 64'hDEADBEEF);
        m_hi = 32'hDEADBEEF; m_lo = 32'h12345678;

        // Reset at busy cycle 3 of a DIV aborts with no later commit.
        @(negedge clk);
        start = 1'b1; op = 4'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_abort", {31'd0, busy, hi}, 64'd0);
        check("rst_abort_lo", 64'(lo), 64'd0);
        repeat (12) @(negedge clk);
        check("rst_no_commit", {busy, hi, lo}, 65'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Randomized ops against the reference model.
        for (int r = 0; r < 60; r++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            e = ref_step(o, a, b);
            issue(o, a, b, n);
            check($sformatf("rnd%0d_op%0d_cycles", r, o), 64'(n), 64'(e));
            check($sformatf("rnd%0d_op%0d_hilo", r, o), {32'(hi), 32'(lo)}, {m_hi, m_lo});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
